pic_pc_fetch: RTL
=================

// Module: pic_pc_fetch
// PURPOSE
//   Program-counter and fetch stage of the 14-bit-instruction core; produces pc_reg, which feeds
//   the program-address stage that drives prog_adr_o. Captures prog_dat_i into the fetch register,
//   early-decodes GOTO/CALL/RETURN/RETLW/RETFIE, and owns the hardware return stack. Also handles
//   execute-stage skip and interrupt vectoring. Program memory read is asynchronous: prog_dat_i is
//   the word at pc_reg in the same cycle.
// PARAMETERS
//   RESET_VECTOR  13'h0000  pc_reg value after reset
//   IRQ_VECTOR    13'h0004  interrupt entry address
//   STACK_DEPTH   8         return-stack entries; power of 2, 2..16
//   NOP_WORD      14'h0000  word inserted on squash/flush
// PORTS
//   clk_i          in   1   core clock, rising edge
//   pon_rst_n_i    in   1   power-on reset, asynchronous, active-low
//   stall_i        in   1   hold all state this cycle
//   prog_dat_i     in   14  instruction word at pc_reg
//   pclath_i       in   5   PCLATH; bits [4:3] form GOTO/CALL target bits [12:11]
//   skip_i         in   1   execute stage: squash the instruction being fetched now
//   irq_i          in   1   level interrupt request, sampled on non-stalled edges
//   pc_reg         out  13  current fetch address
//   instr_o        out  14  fetch register, to execute stage
//   instr_valid_o  out  1   instr_o holds a real (non-squashed) instruction
//   stack_ptr_o    out  $clog2(STACK_DEPTH)  next free stack slot
// BEHAVIOUR
//   Reset (async assert, sync release): pc_reg=RESET_VECTOR, instr_o=NOP_WORD, instr_valid_o=0,
//     stack_ptr_o=0, stack contents=0.
//   stall_i=1: pc_reg, instr_o, instr_valid_o and stack are held; irq_i/skip_i ignored that edge.
//   Non-stalled edge, priority irq_i > skip_i > decode:
//   - irq_i: push pc_reg; pc_reg<=IRQ_VECTOR; instr_o<=NOP_WORD; valid<=0 (fetched word refetched on return)
//   - skip_i: instr_o<=NOP_WORD; valid<=0; pc_reg<=pc_reg+1; no decode of prog_dat_i
//   - else instr_o<=prog_dat_i; valid<=1; next pc from prog_dat_i:
//     GOTO  10_1kkk_kkkk_kkkk -> pc<={pclath_i[4:3],k[10:0]}
//     CALL  10_0kkk_kkkk_kkkk -> push pc_reg+1; pc<={pclath_i[4:3],k[10:0]}
//     RETURN 00_0000_0000_1000, RETFIE 00_0000_0000_1001, RETLW 11_01xx_kkkk_kkkk -> pop; pc<=stack[ptr-1]
//     other -> pc<=pc_reg+1
//   Redirects take effect next cycle: target fetched with zero bubbles.
//   pc arithmetic is 13-bit modulo; 13'h1FFF+1 -> 13'h0000.
//   Push: stack[ptr]<=value, ptr<=ptr+1. Pop: ptr<=ptr-1. Both wrap modulo STACK_DEPTH
//     (9th push overwrites oldest entry; pop from empty reads stack[DEPTH-1]).
//   Only one stack operation per cycle, so no simultaneous push/pop.
//   Reset mid-stall or mid-redirect: reset wins and returns all state to reset values.
// CONFIGURATION
//   STACK_OVF_FLAG_EN defined: adds outputs stk_ovf_o and stk_unf_o (1 bit each, reset 0) and an
//     occupancy counter 0..STACK_DEPTH.
//     - stk_ovf_o is set sticky on a push at full occupancy.
//     - stk_unf_o is set sticky on a pop at zero occupancy.
//     - Both clear only on reset; the wrap behaviour above is unchanged.
//   Not defined: ports and counter absent; overflow/underflow wrap silently.
// STRUCTURE
//   pic_fetch_pkg:
//     - opcode match masks/values for GOTO, CALL, RETURN, RETFIE and RETLW
//     - NOP_WORD default
//     - typedefs pc_t (13b) and instr_t (14b)
//   Sub-module pic_hw_stack (push/pop/ptr/rd_data plus the optional occupancy flags); top holds
//     next-pc mux and fetch register.
// TESTING
//   - Reset, 3 plain words, no stall -> pc 0,1,2,3; instr_o follows words; valid=1 from 1st edge.
//   - GOTO 14'h2ABC at pc 5, pclath_i=5'b11000 -> next pc 13'h1ABC; instr_o=14'h2ABC.
//   - CALL 14'h2010 at pc 7, then RETURN -> stack gets 8, ptr 0->1, pc 0x010 then 8, ptr back to 0.
//   - skip_i with GOTO on prog_dat_i -> instr_o=NOP, valid=0, pc incremented (no jump);
//     irq_i+skip_i same edge -> pc=IRQ_VECTOR, pushed value = old pc_reg.
//   - pc=13'h1FFF plain word -> pc=0; stall_i=1 for 3 cycles mid-sequence -> all outputs frozen.
//   - 9 CALLs then 9 returns -> 9th push overwrites entry 0 (ptr wraps to 1); with
//     STACK_OVF_FLAG_EN, stk_ovf_o=1 after the 9th push and stk_unf_o=1 after the 9th pop.

Source files
------------

// File: rtl/pic_fetch_pkg.sv
// Shared types, opcode decode constants and helpers for the PC/fetch stage
// of the 14-bit-instruction core.
package pic_fetch_pkg;

  typedef logic [12:0] pc_t;
  typedef logic [13:0] instr_t;

  localparam instr_t NOP_WORD_DEF = 14'h0000;

  // GOTO   10_1kkk_kkkk_kkkk
  localparam instr_t GOTO_MASK   = 14'h3800;
  localparam instr_t GOTO_VAL    = 14'h2800;
  // CALL   10_0kkk_kkkk_kkkk
  localparam instr_t CALL_MASK   = 14'h3800;
  localparam instr_t CALL_VAL    = 14'h2000;
  // RETURN 00_0000_0000_1000
  localparam instr_t RETURN_MASK = 14'h3FFF;
  localparam instr_t RETURN_VAL  = 14'h0008;
  // RETFIE 00_0000_0000_1001
  localparam instr_t RETFIE_MASK = 14'h3FFF;
  localparam instr_t RETFIE_VAL  = 14'h0009;
  // RETLW  11_01xx_kkkk_kkkk
  localparam instr_t RETLW_MASK  = 14'h3C00;
  localparam instr_t RETLW_VAL   = 14'h3400;

  function automatic logic op_match(input instr_t w, input instr_t mask, input instr_t val);
    return (w & mask) == val;
  endfunction

  function automatic logic is_ret(input instr_t w);
    return op_match(w, RETURN_MASK, RETURN_VAL) ||
           op_match(w, RETFIE_MASK, RETFIE_VAL) ||
           op_match(w, RETLW_MASK,  RETLW_VAL);
  endfunction

endpackage

// File: rtl/pic_hw_stack.sv
// Hardware return stack. Circular buffer of DEPTH program addresses; push
// and pop both wrap modulo DEPTH, so overflow silently overwrites the
// oldest entry and underflow reads the slot below the pointer.
// Optional feature macro: STACK_OVF_FLAG_EN adds an occupancy counter and
// sticky overflow/underflow flags (cleared only by reset).
// Ports:
//   clk_i, rst_n_i   clock / async active-low reset
//   push_i, pop_i    stack operations (never both in one cycle)
//   push_dat_i       address to push
//   top_o            entry at ptr-1 (value a pop returns)
//   ptr_o            next free slot
//   ovf_o, unf_o     sticky flags (STACK_OVF_FLAG_EN only)
module pic_hw_stack
  import pic_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [12:0]              push_dat_i,
  output logic [12:0]              top_o,
  output logic [$clog2(DEPTH)-1:0] ptr_o
`ifdef STACK_OVF_FLAG_EN
  ,
  output logic                     ovf_o,
  output logic                     unf_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] rd_idx;
  pc_t           mem_q [DEPTH];

  always_comb begin
    ptr_d = ptr_q;
    if (push_i)
      ptr_d = ptr_q + PW'(1);
    else if (pop_i)
      ptr_d = ptr_q - PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (push_i)
        mem_q[ptr_q] <= push_dat_i;
    end
  end

  assign rd_idx = ptr_q - PW'(1);
  assign top_o  = mem_q[rd_idx];
  assign ptr_o  = ptr_q;

`ifdef STACK_OVF_FLAG_EN
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [OW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  // Occupancy saturates at DEPTH / 0; the pointer keeps wrapping regardless.
  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push_i) begin
      if (occ_q == OW'(DEPTH))
        ovf_d = 1'b1;
      else
        occ_d = occ_q + OW'(1);
    end else if (pop_i) begin
      if (occ_q == '0)
        unf_d = 1'b1;
      else
        occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`endif

endmodule

// File: rtl/pic_pc_fetch.sv
// Program counter and fetch stage. Latches the word at pc_reg into the
// fetch register, early-decodes GOTO/CALL/RETURN/RETFIE/RETLW so the branch
// target is fetched on the very next cycle, and drives the return stack.
// Optional feature macro: STACK_OVF_FLAG_EN (adds stk_ovf_o / stk_unf_o).
// Ports:
//   clk_i, pon_rst_n_i  clock / async active-low power-on reset
//   stall_i             hold all state this cycle
//   prog_dat_i          instruction word at pc_reg (asynchronous memory)
//   pclath_i            bits [4:3] supply GOTO/CALL target bits [12:11]
//   skip_i              squash the word being fetched now
//   irq_i               interrupt request (level)
//   pc_reg              current fetch address
//   instr_o             fetch register
//   instr_valid_o       instr_o is a real instruction
//   stack_ptr_o         next free return-stack slot
//   stk_ovf_o/stk_unf_o sticky stack overflow/underflow (optional)
module pic_pc_fetch
  import pic_fetch_pkg::*;
#(
  parameter pc_t         RESET_VECTOR = 13'h0000,
  parameter pc_t         IRQ_VECTOR   = 13'h0004,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter instr_t      NOP_WORD     = NOP_WORD_DEF
) (
  input  logic                           clk_i,
  input  logic                           pon_rst_n_i,
  input  logic                           stall_i,
  input  logic [13:0]                    prog_dat_i,
  input  logic [4:0]                     pclath_i,
  input  logic                           skip_i,
  input  logic                           irq_i,
  output logic [12:0]                    pc_reg,
  output logic [13:0]                    instr_o,
  output logic                           instr_valid_o,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_ptr_o
`ifdef STACK_OVF_FLAG_EN
  ,
  output logic                           stk_ovf_o,
  output logic                           stk_unf_o
`endif
);

  pc_t    pc_q, pc_d;
  instr_t instr_q, instr_d;
  logic   valid_q, valid_d;

  logic   push, pop;
  pc_t    push_dat;
  pc_t    stk_top;
  pc_t    pc_inc;
  pc_t    jmp_tgt;

  // Only the upper PCLATH bits take part in GOTO/CALL targets.
  logic   unused_pclath;
  assign unused_pclath = ^pclath_i[2:0];

  assign pc_inc  = pc_q + 13'd1;
  assign jmp_tgt = {pclath_i[4:3], prog_dat_i[10:0]};

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    push     = 1'b0;
    pop      = 1'b0;
    push_dat = pc_inc;
    if (!stall_i) begin
      if (irq_i) begin
        // Current word is discarded and refetched after RETFIE.
        push     = 1'b1;
        push_dat = pc_q;
        pc_d     = IRQ_VECTOR;
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
      end else if (skip_i) begin
        pc_d    = pc_inc;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d = prog_dat_i;
        valid_d = 1'b1;
        if (op_match(prog_dat_i, GOTO_MASK, GOTO_VAL)) begin
          pc_d = jmp_tgt;
        end else if (op_match(prog_dat_i, CALL_MASK, CALL_VAL)) begin
          push = 1'b1;
          pc_d = jmp_tgt;
        end else if (is_ret(prog_dat_i)) begin
          pop  = 1'b1;
          pc_d = stk_top;
        end else begin
          pc_d = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  pic_hw_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i      (clk_i),
    .rst_n_i    (pon_rst_n_i),
    .push_i     (push),
    .pop_i      (pop),
    .push_dat_i (push_dat),
    .top_o      (stk_top),
    .ptr_o      (stack_ptr_o)
`ifdef STACK_OVF_FLAG_EN
    ,
    .ovf_o      (stk_ovf_o),
    .unf_o      (stk_unf_o)
`endif
  );

  assign pc_reg        = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;

endmodule
